// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;
  localparam int DEPTH_DEF = 1024;
  localparam int WORD_W    = 32;
  localparam int CNT_W     = 11;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  // Requests larger than the memory are clamped so the address never leaves it.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n, input int depth);
    return (int'(n) > depth) ? CNT_W'(depth) : n;
  endfunction
endpackage

// File: rtl/byte_to_word.sv
// Assembles little-endian bytes into 32-bit words; word updates only when complete.
module byte_to_word
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              word_complete,
  output logic [WORD_W-1:0] word
);
  logic [1:0]        idx;
  logic [WORD_W-1:0] asm_reg;
  logic              hs;

  assign hs            = enable & byte_valid;
  assign word_complete = hs & (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      asm_reg <= '0;
      word    <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (hs) begin
      asm_reg[{idx, 3'b000} +: 8] <= byte_data;
      idx                         <= idx + 2'd1;
      // Word output is held between completions so memory data stays stable.
      if (idx == 2'd3) word <= {byte_data, asm_reg[23:0]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory word by word, holding the core in reset meanwhile.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH     = DEPTH_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        core_rst_n
);
  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] req_count;
  logic             clear;
  logic             word_complete;

  assign req_count = clamp_count(word_count, DEPTH);
  assign clear     = (state == IDLE) && start;

  byte_to_word u_b2w (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .enable       (byte_ready),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .word_complete(word_complete),
    .word         (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      busy       <= 1'b0;
      done       <= 1'b0;
      core_rst_n <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          mem_addr <= BASE_ADDR;
          if (req_count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            remaining  <= req_count;
            state      <= RECV;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            core_rst_n <= 1'b0;
          end
        end
        RECV: if (word_complete) begin
          state      <= WRITE;
          byte_ready <= 1'b0;
          mem_we     <= 1'b1;
        end
        WRITE: begin
          mem_we    <= 1'b0;
          remaining <= remaining - 1'b1;
          if (remaining == CNT_W'(1)) begin
            // Address is not advanced past the final word so it never leaves the memory.
            state      <= DONE;
            done       <= 1'b1;
            busy       <= 1'b0;
            core_rst_n <= 1'b1;
          end else begin
            mem_addr   <= mem_addr + 32'd4;
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
